// File: rtl/hex_display_ctrl_if.sv
// Write/display bundle for hex_display_ctrl.
// Bus side drives values in; display side returns segments and status.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_WIDTH = 20
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_mode;
    logic                    blank_lz;
    logic                    blink_en;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic                    busy;
    logic                    overflow;

    modport master (
        output wr_valid, wr_data, wr_mode, blank_lz, blink_en,
        input  wr_ready, seg_out, busy, overflow
    );

    modport slave (
        input  wr_valid, wr_data, wr_mode, blank_lz, blink_en,
        output wr_ready, seg_out, busy, overflow
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: hex or decimal (double-dabble) render.
// Optional blink logic is built only when HEXDISP_BLINK_EN is defined.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_WIDTH = 20,
    parameter int BLINK_DIV  = 25000000
) (
    input logic CLOCK_50,
    input logic reset,
    hex_display_ctrl_if.slave bus
);
    localparam int BW   = 4 * NUM_DIGITS;
    localparam int SW   = 7 * NUM_DIGITS;
    localparam int CNTW = $clog2(DATA_WIDTH + 1);
    localparam int EXTW = (DATA_WIDTH > BW) ? DATA_WIDTH : BW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_LOAD
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_mode;
    logic                  r_blz;
    logic [BW-1:0]         r_bcd;
    logic                  r_cout;
    logic [CNTW-1:0]       r_cnt;
    logic [SW-1:0]         r_seg;
    logic                  r_ovf;

    logic [BW-1:0]   w_adj;
    logic [BW-1:0]   w_bcd_next;
    logic [EXTW-1:0] w_ext;
    logic [BW-1:0]   w_hex;
    logic            w_hex_ovf;
    logic [BW-1:0]   w_nib;
    logic            w_ovf;
    logic [SW-1:0]   w_seg_next;
    logic            w_seen;
    logic [3:0]      w_d;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Double-dabble add-3 step on every BCD digit before the shift
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            else
                w_adj[4*k +: 4] = r_bcd[4*k +: 4];
        end
    end

    assign w_bcd_next = {w_adj[BW-2:0], r_data[DATA_WIDTH-1]};

    // Hex digits come straight from the value; high leftovers mean overflow
    assign w_ext     = EXTW'(r_data);
    assign w_hex     = w_ext[BW-1:0];
    assign w_hex_ovf = (w_ext >> BW) != '0;

    assign w_nib = r_mode ? r_bcd : w_hex;
    assign w_ovf = r_mode ? r_cout : w_hex_ovf;

    // Glyph render with leading-zero blanking; overflow shows dashes
    always_comb begin
        w_seg_next = '1;
        w_seen     = 1'b0;
        w_d        = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_d    = w_nib[4*k +: 4];
            w_seen = w_seen | (w_d != 4'd0);
            if (w_ovf)
                w_seg_next[7*k +: 7] = 7'b0111111;
            else if (r_blz && !w_seen && (k != 0))
                w_seg_next[7*k +: 7] = 7'b1111111;
            else
                w_seg_next[7*k +: 7] = glyph(w_d);
        end
    end

    // Write acceptance, serial conversion and display load
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_mode  <= 1'b0;
            r_blz   <= 1'b0;
            r_bcd   <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
            r_seg   <= '1;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.wr_valid) begin
                        r_data  <= bus.wr_data;
                        r_mode  <= bus.wr_mode;
                        r_blz   <= bus.blank_lz;
                        r_bcd   <= '0;
                        r_cout  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= bus.wr_mode ? S_CONVERT : S_LOAD;
                    end
                end
                S_CONVERT: begin
                    r_bcd  <= w_bcd_next;
                    r_cout <= r_cout | w_adj[BW-1];
                    r_data <= r_data << 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(DATA_WIDTH - 1))
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_seg   <= w_seg_next;
                    r_ovf   <= w_ovf;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_ready = (r_state == S_IDLE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.overflow = r_ovf;

`ifdef HEXDISP_BLINK_EN
    localparam int BCW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [BCW-1:0] r_bcnt;
    logic           r_phase;
    logic           r_mask;

    // Free-running blink divider; mask registered so enable acts next edge
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
            r_mask  <= 1'b0;
        end else begin
            if (r_bcnt == BCW'(BLINK_DIV - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            r_mask <= bus.blink_en && r_phase;
        end
    end

    assign bus.seg_out = r_seg | {SW{r_mask}};
`else
    assign bus.seg_out = r_seg;
`endif

endmodule
